// File: rtl/mem_stage_ctrl.sv
// Memory stage between EX/MEM and MEM/WB: runs one SRAM load/store per
// instruction over a req/ready handshake, freezing the pipeline meanwhile.
module mem_stage_ctrl #(
  parameter int BASE_ADDR = 1024,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val_in,
  input  logic [3:0]        Dest_in,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       MEM_result,
  output logic [3:0]        Dest,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       load_reg, load_next;
  logic              mem_req_next, mem_we_next, mem_err_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [31:0]       mem_wdata_next;
  logic              wb_en_next, mem_r_en_next;
  logic [31:0]       alu_result_next, mem_result_next;
  logic [3:0]        dest_next;
  logic              access;
  logic [31:0]       byte_off;

  assign access   = MEM_R_EN_in | MEM_W_EN_in;
  assign byte_off = ALU_result_in - 32'(BASE_ADDR);
  // Gated by rst so the stall drops the instant reset asserts.
  assign freeze   = rst & (((state_reg == IDLE) & access) | (state_reg == WAIT));

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    load_next       = load_reg;
    mem_req_next    = mem_req;
    mem_we_next     = mem_we;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    mem_err_next    = mem_err;
    wb_en_next      = WB_en;
    mem_r_en_next   = MEM_R_EN;
    alu_result_next = ALU_result;
    mem_result_next = MEM_result;
    dest_next       = Dest;

    case (state_reg)
      IDLE: begin
        if (access) begin
          mem_addr_next  = ADDR_W'(byte_off >> 2);
          mem_wdata_next = ST_val_in;
          mem_we_next    = MEM_W_EN_in;
          mem_req_next   = 1'b1;
          cnt_next       = '0;
          wb_en_next     = 1'b0;
          mem_r_en_next  = 1'b0;
          state_next     = WAIT;
        end else begin
          wb_en_next      = WB_en_in;
          mem_r_en_next   = MEM_R_EN_in;
          alu_result_next = ALU_result_in;
          dest_next       = Dest_in;
          mem_result_next = '0;
        end
      end
      WAIT: begin
        wb_en_next    = 1'b0;
        mem_r_en_next = 1'b0;
        if (mem_ready) begin
          // Stores (including a simultaneous R+W) never return load data.
          mem_req_next = 1'b0;
          load_next    = mem_we ? 32'd0 : mem_rdata;
          state_next   = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          mem_req_next = 1'b0;
          load_next    = '0;
          mem_err_next = 1'b1;
          state_next   = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        wb_en_next      = WB_en_in;
        mem_r_en_next   = MEM_R_EN_in;
        alu_result_next = ALU_result_in;
        dest_next       = Dest_in;
        mem_result_next = load_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      load_reg   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_err    <= 1'b0;
      WB_en      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      ALU_result <= '0;
      MEM_result <= '0;
      Dest       <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      load_reg   <= load_next;
      mem_req    <= mem_req_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      mem_err    <= mem_err_next;
      WB_en      <= wb_en_next;
      MEM_R_EN   <= mem_r_en_next;
      ALU_result <= alu_result_next;
      MEM_result <= mem_result_next;
      Dest       <= dest_next;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, reset corner cases and a
// random instruction stream checked against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int BASE    = 1024;
  localparam int TIMEOUT = 64;

  logic        clk, rst;
  logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_result_in, ST_val_in;
  logic [3:0]  Dest_in;
  logic        freeze, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        WB_en, MEM_R_EN;
  logic [31:0] ALU_result, MEM_result;
  logic [3:0]  Dest;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  // Last retired MEM/WB values, which must hold during a stall.
  logic [31:0] last_alu, last_res;
  logic [3:0]  last_dest;

  mem_stage_ctrl #(.BASE_ADDR(BASE), .ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
    .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
    .MEM_result(MEM_result), .Dest(Dest), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic        wb, r, w;
    logic [31:0] alu, st;
    logic [3:0]  dest;
    int          lat;
    logic [31:0] rdata;
    int          e_freeze;
    logic [15:0] e_addr;
    logic        e_we;
    logic [31:0] e_res;
    logic        e_err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; drives one instruction, plays the SRAM
  // (ready on the lat-th request cycle) and checks it as it retires.
  task automatic run_instr(input string tag, input vec_t v);
    int          fz, rq, e_req;
    bit          done, stall_bad, done_req_bad;
    logic [15:0] got_addr;
    logic        got_we;
    logic [31:0] got_wdata;
    fz = 0; rq = 0; done = 0; stall_bad = 0; done_req_bad = 0;
    got_addr = '0; got_we = 0; got_wdata = '0;
    e_req = (v.r | v.w) ? ((v.lat > TIMEOUT) ? TIMEOUT : v.lat) : 0;
    WB_en_in = v.wb; MEM_R_EN_in = v.r; MEM_W_EN_in = v.w;
    ALU_result_in = v.alu; ST_val_in = v.st; Dest_in = v.dest;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (freeze) begin
        fz++;
        if (fz > 1 && (WB_en !== 1'b0 || MEM_R_EN !== 1'b0 || ALU_result !== last_alu ||
                       Dest !== last_dest || MEM_result !== last_res))
          stall_bad = 1;
      end
      if (mem_req) begin
        rq++;
        if (rq == 1) begin
          got_addr = mem_addr; got_we = mem_we; got_wdata = mem_wdata;
        end
        mem_ready = (rq == v.lat);
        mem_rdata = (rq == v.lat) ? v.rdata : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (!freeze) begin
        if (mem_req) done_req_bad = 1;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_retire: freeze still high after 200 cycles, required release", tag);
    end
    chk({tag, "_freeze_cycles"}, fz, v.e_freeze);
    chk({tag, "_req_cycles"}, rq, e_req);
    chk({tag, "_stall_hold"}, {31'd0, stall_bad}, 0);
    chk({tag, "_done_req"}, {31'd0, done_req_bad}, 0);
    if (v.r | v.w) begin
      chk({tag, "_mem_addr"}, {16'd0, got_addr}, {16'd0, v.e_addr});
      chk({tag, "_mem_we"}, {31'd0, got_we}, {31'd0, v.e_we});
      chk({tag, "_mem_wdata"}, got_wdata, v.st);
    end
    chk({tag, "_WB_en"}, {31'd0, WB_en}, {31'd0, v.wb});
    chk({tag, "_MEM_R_EN"}, {31'd0, MEM_R_EN}, {31'd0, v.r});
    chk({tag, "_ALU_result"}, ALU_result, v.alu);
    chk({tag, "_Dest"}, {28'd0, Dest}, {28'd0, v.dest});
    chk({tag, "_MEM_result"}, MEM_result, v.e_res);
    chk({tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, v.e_err});
    last_alu = v.alu; last_dest = v.dest; last_res = v.e_res;
  endtask

  initial begin
    vec_t        v;
    logic        err_m;
    int          eff;
    bit          to;

    //         wb r  w  alu            st            dest   lat  rdata          frz addr      we res            err
    tbl[0]  = '{1, 0, 0, 32'h55,       32'h0,        4'd3,  1,   32'h0,         0,  16'h0,    0, 32'h0,         0};
    tbl[1]  = '{1, 1, 0, 32'd1032,     32'h0,        4'd1,  3,   32'hDEADBEEF,  4,  16'd2,    0, 32'hDEADBEEF,  0};
    tbl[2]  = '{0, 0, 1, 32'd1028,     32'h1234,     4'd0,  1,   32'h0,         2,  16'd1,    1, 32'h0,         0};
    tbl[3]  = '{1, 1, 1, 32'd1040,     32'hA5A5,     4'd2,  2,   32'hCAFE,      3,  16'd4,    1, 32'h0,         0};
    tbl[4]  = '{1, 1, 0, 32'd281024,   32'h0,        4'd9,  1,   32'h13579BDF,  2,  16'd4464, 0, 32'h13579BDF,  0};
    tbl[5]  = '{0, 0, 1, 32'd1020,     32'hFFFF0000, 4'd4,  2,   32'h0,         3,  16'hFFFF, 1, 32'h0,         0};
    tbl[6]  = '{1, 1, 0, 32'd1024,     32'h0,        4'd6,  64,  32'h77,        65, 16'd0,    0, 32'h77,        0};
    tbl[7]  = '{1, 1, 0, 32'd1036,     32'h0,        4'd8,  100, 32'h99,        65, 16'd3,    0, 32'h0,         1};
    tbl[8]  = '{0, 0, 0, 32'hAB,       32'h0,        4'd7,  1,   32'h0,         0,  16'h0,    0, 32'h0,         1};
    tbl[9]  = '{1, 1, 0, 32'd1048,     32'h0,        4'd10, 1,   32'h11112222,  2,  16'd6,    0, 32'h11112222,  1};
    tbl[10] = '{0, 0, 1, 32'd1052,     32'h3333,     4'd11, 4,   32'h0,         5,  16'd7,    1, 32'h0,         1};

    // Reset with a load on the inputs: nothing may stall or request.
    rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    WB_en_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0;
    ALU_result_in = 32'd1032; ST_val_in = 32'h5; Dest_in = 4'd2;
    last_alu = '0; last_dest = '0; last_res = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_freeze", {31'd0, freeze}, 0);
    chk("reset_mem_req", {31'd0, mem_req}, 0);
    chk("reset_outputs", {WB_en, MEM_R_EN, mem_err, mem_we, Dest, mem_addr}, 0);
    chk("reset_alu", ALU_result, 0);
    chk("reset_mem_result", MEM_result, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_instr($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset in the middle of a WAIT.
    WB_en_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0;
    ALU_result_in = 32'd1044; ST_val_in = 32'h5A5A; Dest_in = 4'd5;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midwait_req_before", {31'd0, mem_req}, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midwait_req", {31'd0, mem_req}, 0);
    chk("midwait_freeze", {31'd0, freeze}, 0);
    chk("midwait_ctrl", {WB_en, MEM_R_EN, mem_err, mem_we, Dest}, 0);
    chk("midwait_addr", {16'd0, mem_addr}, 0);
    chk("midwait_wdata", mem_wdata, 0);
    chk("midwait_alu", ALU_result, 0);
    @(negedge clk);
    rst = 1'b1;
    last_alu = '0; last_dest = '0; last_res = '0;
    v = '{1, 1, 0, 32'd1060, 32'h0, 4'd12, 2, 32'hBEEF0001, 3, 16'd9, 0, 32'hBEEF0001, 0};
    run_instr("post_reset", v);

    // Random stream against a transaction-level model.
    err_m = 1'b0;
    for (int n = 0; n < 150; n++) begin
      v.wb    = 1'($urandom_range(0, 1));
      v.r     = 1'($urandom_range(0, 1));
      v.w     = ($urandom_range(0, 3) == 0);
      v.st    = $urandom;
      v.dest  = 4'($urandom);
      v.rdata = $urandom;
      v.lat   = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 5);
      v.alu   = (v.r | v.w) ? 32'(BASE + $urandom_range(0, 300000)) : $urandom;
      eff        = (v.lat > TIMEOUT) ? TIMEOUT : v.lat;
      to         = (v.r | v.w) && (v.lat > TIMEOUT);
      v.e_freeze = (v.r | v.w) ? 1 + eff : 0;
      v.e_addr   = 16'(((v.alu - 32'(BASE)) / 4) % 65536);
      v.e_we     = v.w;
      v.e_res    = (v.r && !v.w && !to) ? v.rdata : 32'h0;
      err_m      = err_m | to;
      v.e_err    = err_m;
      run_instr($sformatf("rnd%0d", n), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
